// File: rtl/reed_conditioner_if.sv
// Reed conditioner signal bundle: raw reed level and enable in,
// conditioned pulse, period measurement and stop flag out.
interface reed_conditioner_if #(
  parameter int PERIOD_W = 12
) ();
  logic                reed_raw;
  logic                enable;
  logic                reed_pulse;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                stopped;

  // Driver of the raw switch and enable; consumer of the conditioned outputs.
  modport master (
    output reed_raw,
    output enable,
    input  reed_pulse,
    input  period,
    input  period_valid,
    input  stopped
  );

  // The conditioner itself.
  modport slave (
    input  reed_raw,
    input  enable,
    output reed_pulse,
    output period,
    output period_valid,
    output stopped
  );
endinterface

// File: rtl/reed_conditioner.sv
// Reed switch conditioner: synchronises and debounces a bouncy wheel reed
// switch, emits one pulse per accepted closure, measures the cycle count
// between consecutive closures and flags a stopped wheel after a timeout.
module reed_conditioner #(
  parameter int DEB_CYCLES = 8,
  parameter int PERIOD_W   = 12,
  parameter int TIMEOUT    = 2000
) (
  input  logic              clock,
  input  logic              reset,
  reed_conditioner_if.slave bus
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0]    DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] TIMEOUT_VAL = PERIOD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_OPEN      = 2'd0,
    ST_DEB_CLOSE = 2'd1,
    ST_CLOSED    = 2'd2,
    ST_DEB_OPEN  = 2'd3
  } state_t;

  logic                s1_r;
  logic                s2_r;
  state_t              state_r;
  state_t              state_nxt_s;
  logic [DEB_W-1:0]    deb_cnt_r;
  logic [DEB_W-1:0]    deb_cnt_nxt_s;
  logic                close_s;
  logic                emit_s;
  logic [PERIOD_W-1:0] per_cnt_r;
  logic                pulse_r;
  logic [PERIOD_W-1:0] period_r;
  logic                valid_r;
  logic                stopped_r;

  // Two-flop synchroniser for the asynchronous reed level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= bus.reed_raw;
      s2_r <= s1_r;
    end
  end

  // Debounce FSM state and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_OPEN;
      deb_cnt_r <= {DEB_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      deb_cnt_r <= deb_cnt_nxt_s;
    end
  end

  // Debounce next-state logic; close_s marks the accepted closure edge.
  always_comb begin
    state_nxt_s   = state_r;
    deb_cnt_nxt_s = deb_cnt_r;
    close_s       = 1'b0;
    case (state_r)
      ST_OPEN: begin
        if (s2_r) begin
          state_nxt_s   = ST_DEB_CLOSE;
          deb_cnt_nxt_s = {DEB_W{1'b0}};
        end else begin
          state_nxt_s   = ST_OPEN;
          deb_cnt_nxt_s = {DEB_W{1'b0}};
        end
      end
      ST_DEB_CLOSE: begin
        if (!s2_r) begin
          state_nxt_s   = ST_OPEN;
          deb_cnt_nxt_s = {DEB_W{1'b0}};
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nxt_s   = ST_CLOSED;
          deb_cnt_nxt_s = {DEB_W{1'b0}};
          close_s       = 1'b1;
        end else begin
          state_nxt_s   = ST_DEB_CLOSE;
          deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
        end
      end
      ST_CLOSED: begin
        if (!s2_r) begin
          state_nxt_s   = ST_DEB_OPEN;
          deb_cnt_nxt_s = {DEB_W{1'b0}};
        end else begin
          state_nxt_s   = ST_CLOSED;
          deb_cnt_nxt_s = {DEB_W{1'b0}};
        end
      end
      ST_DEB_OPEN: begin
        if (s2_r) begin
          state_nxt_s   = ST_CLOSED;
          deb_cnt_nxt_s = {DEB_W{1'b0}};
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nxt_s   = ST_OPEN;
          deb_cnt_nxt_s = {DEB_W{1'b0}};
        end else begin
          state_nxt_s   = ST_DEB_OPEN;
          deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
        end
      end
      default: begin
        state_nxt_s   = ST_OPEN;
        deb_cnt_nxt_s = {DEB_W{1'b0}};
      end
    endcase
  end

  // A closure only becomes visible (and affects timing) when enabled.
  assign emit_s = close_s & bus.enable;

  // Pulse, period measurement and stop detection; a pulse beats a timeout
  // arriving on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pulse_r   <= 1'b0;
      per_cnt_r <= {PERIOD_W{1'b0}};
      period_r  <= {PERIOD_W{1'b0}};
      valid_r   <= 1'b0;
      stopped_r <= 1'b1;
    end else begin
      pulse_r <= emit_s;
      valid_r <= 1'b0;
      if (emit_s) begin
        per_cnt_r <= PERIOD_W'(1);
        if (stopped_r) begin
          stopped_r <= 1'b0;
        end else begin
          period_r <= per_cnt_r;
          valid_r  <= 1'b1;
        end
      end else if (per_cnt_r == TIMEOUT_VAL) begin
        stopped_r <= 1'b1;
      end else begin
        per_cnt_r <= per_cnt_r + PERIOD_W'(1);
      end
    end
  end

  assign bus.reed_pulse   = pulse_r;
  assign bus.period       = period_r;
  assign bus.period_valid = valid_r;
  assign bus.stopped      = stopped_r;

endmodule

// File: tb/tb_reed_conditioner.sv
// Self-checking bench for reed_conditioner: a scoreboard queue of expected
// pulses (edge number, period_valid, period) is filled as closures are
// driven and drained by a monitor that watches the DUT outputs.
module tb_reed_conditioner;

  localparam int DEB = 4;
  localparam int PW  = 12;
  localparam int TMO = 100;

  logic clock = 1'b0;
  logic reset;

  reed_conditioner_if #(.PERIOD_W(PW)) bus ();

  reed_conditioner #(
    .DEB_CYCLES(DEB),
    .PERIOD_W  (PW),
    .TIMEOUT   (TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  // Count rising edges; read at the falling edge it is the last edge number.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          valid;
    logic [PW-1:0] period;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_x;
  int            errors = 0;
  int            checks = 0;
  logic          m_stopped = 1'b1;
  int            m_last = 0;
  logic [PW-1:0] m_period = '0;

  // Model of the expected pulse accepted at edge e.
  task automatic expect_pulse(input int e);
    exp_t x;
    x.cyc = e;
    if (!m_stopped && (e - m_last) <= TMO) begin
      x.valid  = 1'b1;
      x.period = PW'(e - m_last);
      m_period = x.period;
    end else begin
      x.valid  = 1'b0;
      x.period = m_period;
    end
    m_stopped = 1'b0;
    m_last    = e;
    exp_q.push_back(x);
  endtask

  // Monitor: every pulse or strobe must match the head of the scoreboard.
  logic prev_pulse = 1'b0;
  logic prev_valid = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (bus.reed_pulse === 1'b1) begin
        checks++;
        if (prev_pulse === 1'b1) begin
          errors++;
          $display("FAIL pulse_width cyc=%0d: reed_pulse high two cycles in a row, required one", cyc);
        end
      end
      if (bus.period_valid === 1'b1) begin
        checks++;
        if (prev_valid === 1'b1) begin
          errors++;
          $display("FAIL valid_width cyc=%0d: period_valid high two cycles in a row, required one", cyc);
        end
      end
      if (bus.reed_pulse === 1'b1 || bus.period_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d: pulse=%b valid=%b, required no output", cyc, bus.reed_pulse, bus.period_valid);
        end else begin
          mon_x = exp_q.pop_front();
          checks += 3;
          if (cyc !== mon_x.cyc) begin
            errors++;
            $display("FAIL pulse_cycle: got edge %0d, required edge %0d", cyc, mon_x.cyc);
          end
          if (bus.period_valid !== mon_x.valid) begin
            errors++;
            $display("FAIL period_valid cyc=%0d: got %b, required %b", cyc, bus.period_valid, mon_x.valid);
          end
          if (bus.period !== mon_x.period) begin
            errors++;
            $display("FAIL period cyc=%0d: got %0d, required %0d", cyc, bus.period, mon_x.period);
          end
        end
      end
      prev_pulse = bus.reed_pulse;
      prev_valid = bus.period_valid;
    end
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Assumes caller is at a falling edge: close the switch.
  task automatic press(input logic en);
    bus.reed_raw = 1'b1;
    if (en) expect_pulse(cyc + 1 + DEB + 2);
  endtask

  task automatic do_closure(input int hold, input logic en);
    @(negedge clock);
    press(en);
    repeat (hold) @(negedge clock);
    bus.reed_raw = 1'b0;
    repeat (DEB + 4) @(negedge clock);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Bounded wait for all expected pulses; leftovers are missed pulses.
  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d expected pulse(s) never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_out(input string name, input logic [PW-1:0] per_exp, input logic stp_exp);
    checks += 2;
    if (bus.period !== per_exp) begin
      errors++;
      $display("FAIL %s_period: got %0d, required %0d", name, bus.period, per_exp);
    end
    if (bus.stopped !== stp_exp) begin
      errors++;
      $display("FAIL %s_stopped: got %b, required %b", name, bus.stopped, stp_exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks += 2;
    if (bus.reed_pulse !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: got %b, required 0", name, bus.reed_pulse);
    end
    if (bus.period_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid: got %b, required 0", name, bus.period_valid);
    end
    check_out(name, '0, 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b1;
    m_stopped = 1'b1;
    m_period  = '0;
  endtask

  task automatic test_clean_closure;
    @(negedge clock);
    check_out("clean_pre", '0, 1'b1);
    do_closure(20, 1'b1);
    repeat (20) @(negedge clock);
    drain("clean");
    check_out("clean_post", '0, 1'b0);
  endtask

  task automatic test_bounce;
    @(negedge clock); bus.reed_raw = 1'b1;
    @(negedge clock); bus.reed_raw = 1'b1;
    @(negedge clock); bus.reed_raw = 1'b0;
    @(negedge clock); press(1'b1);
    repeat (15) @(negedge clock);
    bus.reed_raw = 1'b0;
    repeat (DEB + 4) @(negedge clock);
    drain("bounce");
    check_out("bounce", m_period, 1'b0);
  endtask

  task automatic test_back_to_back;
    int start;
    @(negedge clock);
    start = cyc;
    press(1'b1);
    repeat (20) @(negedge clock);
    bus.reed_raw = 1'b0;
    wait_until(start + 50);
    press(1'b1);
    repeat (20) @(negedge clock);
    bus.reed_raw = 1'b0;
    repeat (DEB + 4) @(negedge clock);
    drain("two_closures");
    check_out("two_closures", PW'(50), 1'b0);
  endtask

  task automatic test_timeout;
    logic [PW-1:0] held;
    held = m_period;
    repeat (TMO + 5) @(negedge clock);
    check_out("timeout", held, 1'b1);
    do_closure(10, 1'b1);
    drain("after_stop");
    check_out("after_stop", held, 1'b0);
  endtask

  task automatic test_timeout_boundary;
    wait_until(m_last + TMO - DEB - 3);
    press(1'b1);
    repeat (10) @(negedge clock);
    bus.reed_raw = 1'b0;
    repeat (DEB + 4) @(negedge clock);
    drain("boundary");
    check_out("boundary", PW'(TMO), 1'b0);
  endtask

  task automatic test_enable_mask;
    bus.enable = 1'b0;
    do_closure(20, 1'b0);
    drain("masked");
    check_out("masked", m_period, 1'b0);
    bus.enable = 1'b1;
    do_closure(10, 1'b1);
    drain("after_mask");
    check_out("after_mask", m_period, 1'b0);
  endtask

  task automatic test_reset_mid_debounce;
    @(negedge clock);
    bus.reed_raw = 1'b1;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_reset_vals("mid_reset");
    m_stopped = 1'b1;
    m_period  = '0;
    @(negedge clock);
    reset = 1'b1;
    expect_pulse(cyc + 1 + DEB + 2);
    repeat (15) @(negedge clock);
    bus.reed_raw = 1'b0;
    repeat (DEB + 4) @(negedge clock);
    drain("post_reset");
    check_out("post_reset", '0, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    bus.reed_raw = 1'b0;
    bus.enable   = 1'b1;
    test_reset();
    test_clean_closure();
    test_bounce();
    test_back_to_back();
    test_timeout();
    test_timeout_boundary();
    test_enable_mask();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
